// File: rtl/store_ring_queue_pkg.sv
// Shared types and byte-enable helpers for the store ring queue.
// Imported by store_ring_queue and sq_fwd_match.
package store_ring_queue_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    SQ_FREE,
    SQ_ALLOC,
    SQ_EXEC,
    SQ_RET
  } sq_state_t;

  typedef struct packed {
    sq_state_t   state;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } sq_entry_t;

  function automatic logic [3:0] size_be(
    input logic [1:0] size
  );
    unique case (size)
      BYTE:    size_be = 4'b0001;
      HALF:    size_be = 4'b0011;
      default: size_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(
    input logic [1:0] size,
    input logic [1:0] off
  );
    lane_be = size_be(size) << off;
  endfunction

endpackage

// File: rtl/sq_fwd_match.sv
// Age-bounded youngest-overlap search for one load port.
// SQ_STORE_FWD_EN enables data forwarding; otherwise overlap stalls.
module sq_fwd_match
  import store_ring_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IW    = $clog2(DEPTH)
) (
  input  sq_entry_t   ent [DEPTH],
  input  logic [IW:0] head,
  input  logic [IW:0] age,
  input  logic        valid,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic        hit,
  output logic        stall,
  output logic [31:0] data
);

  typedef logic [IW:0]   ptr_t;
  typedef logic [IW-1:0] idx_t;

  ptr_t        span;
  idx_t        idx;
  logic [3:0]  lbe;
  logic        older_alloc;
  logic        overlap;
  logic [3:0]  ybe;
  logic [31:0] ydata;

  // Walk oldest to youngest so the last overlap seen is the youngest.
  always_comb begin
    span        = age - head;
    lbe         = lane_be(size, addr[1:0]);
    idx         = '0;
    older_alloc = 1'b0;
    overlap     = 1'b0;
    ybe         = '0;
    ydata       = '0;
    for (int r = 0; r < DEPTH; r++) begin
      idx = head[IW-1:0] + idx_t'(r);
      if (ptr_t'(r) < span) begin
        if (ent[idx].state == SQ_ALLOC) begin
          older_alloc = 1'b1;
        end else if (ent[idx].state != SQ_FREE &&
                     ent[idx].addr[31:2] == addr[31:2] &&
                     |(ent[idx].be & lbe)) begin
          overlap = 1'b1;
          ybe     = ent[idx].be;
          ydata   = ent[idx].data;
        end
      end
    end
  end

`ifdef SQ_STORE_FWD_EN
  logic [31:0] raw;
  logic        full_cov;

  always_comb begin
    raw      = ydata >> {addr[1:0], 3'b000};
    full_cov = (ybe & lbe) == lbe;
    hit      = valid & ~older_alloc & overlap & full_cov;
    stall    = valid & (older_alloc | (overlap & ~full_cov));
    data     = '0;
    if (hit) begin
      unique case (size)
        BYTE: data = is_unsigned ? {24'h0, raw[7:0]}
                                 : {{24{raw[7]}}, raw[7:0]};
        HALF: data = is_unsigned ? {16'h0, raw[15:0]}
                                 : {{16{raw[15]}}, raw[15:0]};
        default: data = raw;
      endcase
    end
  end
`else
  logic unused_ok;

  assign unused_ok = ^{is_unsigned, ybe, ydata};
  assign hit       = 1'b0;
  assign data      = '0;
  assign stall     = valid & (older_alloc | overlap);
`endif

endmodule

// File: rtl/store_ring_queue.sv
// Circular store queue: dispatch, execute capture, retire, D-cache drain.
// Define SQ_STORE_FWD_EN for store-to-load data forwarding.
module store_ring_queue
  import store_ring_queue_pkg::*;
#(
  parameter  int DEPTH    = 8,
  parameter  int WAYS     = 2,
  parameter  int LD_PORTS = 2,
  parameter  int IW       = $clog2(DEPTH),
  localparam int NW       = $clog2(WAYS) + 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NW-1:0]              dis_num,
  output logic [WAYS*IW-1:0]         dis_idx,
  output logic [IW:0]                dis_tail,
  output logic [IW:0]                free_count,
  input  logic [WAYS-1:0]            ex_valid,
  input  logic [WAYS*IW-1:0]         ex_idx,
  input  logic [WAYS*32-1:0]         ex_addr,
  input  logic [WAYS*32-1:0]         ex_data,
  input  logic [WAYS*2-1:0]          ex_size,
  input  logic [NW-1:0]              ret_num,
  output logic                       cm_valid,
  input  logic                       cm_ready,
  output logic [31:0]                cm_addr,
  output logic [31:0]                cm_data,
  output logic [3:0]                 cm_be,
  input  logic                       rb_valid,
  input  logic [IW:0]                rb_tail,
  input  logic [LD_PORTS-1:0]        ld_valid,
  input  logic [LD_PORTS*32-1:0]     ld_addr,
  input  logic [LD_PORTS*2-1:0]      ld_size,
  input  logic [LD_PORTS-1:0]        ld_unsigned,
  input  logic [LD_PORTS*(IW+1)-1:0] ld_age,
  output logic [LD_PORTS-1:0]        ld_hit,
  output logic [LD_PORTS*32-1:0]     ld_data,
  output logic [LD_PORTS-1:0]        ld_stall
);

  typedef logic [IW:0]   ptr_t;
  typedef logic [IW-1:0] idx_t;

  sq_entry_t        ent [DEPTH];
  sq_entry_t        hd;
  ptr_t             head, rptr, tail;
  ptr_t             head_n, tail_n, rb_span;
  idx_t             rb_off;
  logic [DEPTH-1:0] rb_kill;
  logic             fire;

  assign hd       = ent[head[IW-1:0]];
  assign cm_valid = hd.state == SQ_RET;
  assign fire     = cm_valid & cm_ready;
  assign cm_addr  = cm_valid ? hd.addr : '0;
  assign cm_data  = cm_valid ? hd.data : '0;
  assign cm_be    = cm_valid ? hd.be : '0;
  assign dis_tail = tail;

  assign head_n  = head + ptr_t'(fire);
  assign tail_n  = rb_valid ? rb_tail : tail + ptr_t'(dis_num);
  assign rb_span = tail - rb_tail;

  always_comb begin
    dis_idx = '0;
    for (int w = 0; w < WAYS; w++)
      dis_idx[w*IW +: IW] = tail[IW-1:0] + idx_t'(w);
  end

  // Slots in [rb_tail, tail) are the wrong-path allocations.
  always_comb begin
    rb_kill = '0;
    rb_off  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rb_off     = idx_t'(i) - rb_tail[IW-1:0];
      rb_kill[i] = rb_valid && ({1'b0, rb_off} < rb_span);
    end
  end

  // Later assignments win: rollback overrides a same-cycle ex write.
  always_ff @(posedge clock) begin
    if (reset) begin
      head       <= '0;
      rptr       <= '0;
      tail       <= '0;
      free_count <= ptr_t'(DEPTH);
      for (int i = 0; i < DEPTH; i++)
        ent[i] <= '0;
    end else begin
      head       <= head_n;
      rptr       <= rptr + ptr_t'(ret_num);
      tail       <= tail_n;
      free_count <= ptr_t'(DEPTH) - (tail_n - head_n);
      if (!rb_valid)
        for (int w = 0; w < WAYS; w++)
          if (NW'(w) < dis_num)
            ent[tail[IW-1:0] + idx_t'(w)].state <= SQ_ALLOC;
      for (int w = 0; w < WAYS; w++)
        if (ex_valid[w] &&
            ent[ex_idx[w*IW +: IW]].state == SQ_ALLOC)
          ent[ex_idx[w*IW +: IW]] <= '{
            state: SQ_EXEC,
            addr:  {ex_addr[w*32+2 +: 30], 2'b00},
            data:  ex_data[w*32 +: 32] <<
                   {ex_addr[w*32 +: 2], 3'b000},
            be:    lane_be(ex_size[w*2 +: 2],
                           ex_addr[w*32 +: 2])
          };
      for (int i = 0; i < DEPTH; i++)
        if (rb_kill[i])
          ent[i].state <= SQ_FREE;
      for (int w = 0; w < WAYS; w++)
        if (NW'(w) < ret_num)
          ent[rptr[IW-1:0] + idx_t'(w)].state <= SQ_RET;
      if (fire)
        ent[head[IW-1:0]].state <= SQ_FREE;
    end
  end

  for (genvar p = 0; p < LD_PORTS; p++) begin : g_ld
    sq_fwd_match #(
      .DEPTH(DEPTH),
      .IW   (IW)
    ) u_match (
      .ent        (ent),
      .head       (head),
      .age        (ld_age[p*(IW+1) +: IW+1]),
      .valid      (ld_valid[p]),
      .addr       (ld_addr[p*32 +: 32]),
      .size       (ld_size[p*2 +: 2]),
      .is_unsigned(ld_unsigned[p]),
      .hit        (ld_hit[p]),
      .stall      (ld_stall[p]),
      .data       (ld_data[p*32 +: 32])
    );
  end

endmodule

// File: tb/tb_store_ring_queue.sv
// Scoreboard bench for store_ring_queue (DEPTH=8, WAYS=2, 2 load ports).
// Expectations follow SQ_STORE_FWD_EN when it is defined.
module tb_store_ring_queue;
  import store_ring_queue_pkg::*;

`ifdef SQ_STORE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  dis_num = '0;
  logic [5:0]  dis_idx;
  logic [3:0]  dis_tail;
  logic [3:0]  free_count;
  logic [1:0]  ex_valid = '0;
  logic [5:0]  ex_idx = '0;
  logic [63:0] ex_addr = '0;
  logic [63:0] ex_data = '0;
  logic [3:0]  ex_size = '0;
  logic [1:0]  ret_num = '0;
  logic        cm_valid;
  logic        cm_ready = 1'b0;
  logic [31:0] cm_addr;
  logic [31:0] cm_data;
  logic [3:0]  cm_be;
  logic        rb_valid = 1'b0;
  logic [3:0]  rb_tail = '0;
  logic [1:0]  ld_valid = '0;
  logic [63:0] ld_addr = '0;
  logic [3:0]  ld_size = '0;
  logic [1:0]  ld_unsigned = '0;
  logic [7:0]  ld_age = '0;
  logic [1:0]  ld_hit;
  logic [63:0] ld_data;
  logic [1:0]  ld_stall;

  int total = 0;
  int fails = 0;
  logic [67:0] sb [$];

  store_ring_queue dut (
    .clock(clock), .reset(reset),
    .dis_num(dis_num), .dis_idx(dis_idx),
    .dis_tail(dis_tail), .free_count(free_count),
    .ex_valid(ex_valid), .ex_idx(ex_idx),
    .ex_addr(ex_addr), .ex_data(ex_data),
    .ex_size(ex_size), .ret_num(ret_num),
    .cm_valid(cm_valid), .cm_ready(cm_ready),
    .cm_addr(cm_addr), .cm_data(cm_data), .cm_be(cm_be),
    .rb_valid(rb_valid), .rb_tail(rb_tail),
    .ld_valid(ld_valid), .ld_addr(ld_addr),
    .ld_size(ld_size), .ld_unsigned(ld_unsigned),
    .ld_age(ld_age), .ld_hit(ld_hit),
    .ld_data(ld_data), .ld_stall(ld_stall)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not end, want finish");
    $fatal(1, "watchdog");
  end

  // Commit monitor: every fire must match the next expected store.
  always @(negedge clock) begin
    if (!reset && cm_valid && cm_ready) begin
      total++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL cm_extra: got %h/%h/%h, want none",
                 cm_addr, cm_data, cm_be);
      end else if ({cm_addr, cm_data, cm_be} !== sb[0]) begin
        fails++;
        $display("FAIL cm_fire: got %h/%h/%h, want %h/%h/%h",
                 cm_addr, cm_data, cm_be,
                 sb[0][67:36], sb[0][35:4], sb[0][3:0]);
        void'(sb.pop_front());
      end else begin
        void'(sb.pop_front());
      end
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    dis_num  = '0;
    ret_num  = '0;
    ex_valid = '0;
    rb_valid = 1'b0;
  endtask

  task automatic ex(input int lane, input int idx,
                    input logic [31:0] a, input logic [31:0] d,
                    input logic [1:0] sz);
    ex_valid[lane]        = 1'b1;
    ex_idx[lane*3 +: 3]   = 3'(idx);
    ex_addr[lane*32 +: 32] = a;
    ex_data[lane*32 +: 32] = d;
    ex_size[lane*2 +: 2]  = sz;
  endtask

  task automatic exp_cm(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be);
    sb.push_back({a, d, be});
  endtask

  task automatic ldq(input int p, input logic [31:0] a,
                     input logic [1:0] sz, input logic u,
                     input logic [3:0] age);
    ld_valid[p]          = 1'b1;
    ld_addr[p*32 +: 32]  = a;
    ld_size[p*2 +: 2]    = sz;
    ld_unsigned[p]       = u;
    ld_age[p*4 +: 4]     = age;
  endtask

  task automatic chk_ld(input string name, input int p,
                        input logic h, input logic s,
                        input logic [31:0] d);
    chk({name, ".hit"}, 32'(ld_hit[p]), 32'(h));
    chk({name, ".stall"}, 32'(ld_stall[p]), 32'(s));
    chk({name, ".data"}, ld_data[p*32 +: 32], d);
  endtask

  initial begin
    repeat (3) step();
    reset = 1'b0;
    chk("rst_free", 32'(free_count), 32'd8);
    chk("rst_cm_valid", 32'(cm_valid), 32'd0);
    chk("rst_cm_addr", cm_addr, 32'd0);
    chk("rst_dis_idx", 32'(dis_idx), 32'h08);
    chk("rst_dis_tail", 32'(dis_tail), 32'd0);
    chk_ld("rst_ld0", 0, 1'b0, 1'b0, 32'd0);

    // Basic dispatch / execute / retire / drain.
    dis_num = 2'd2;
    step();
    chk("a_free", 32'(free_count), 32'd6);
    chk("a_dis_idx", 32'(dis_idx), 32'h1A);
    ex(0, 0, 32'h200, 32'h11111111, WORD);
    ex(1, 1, 32'h205, 32'h000000AB, BYTE);
    step();
    exp_cm(32'h200, 32'h11111111, 4'hF);
    exp_cm(32'h204, 32'h0000AB00, 4'h2);
    ret_num = 2'd2;
    cm_ready = 1'b1;
    step();
    chk("a_cm_valid", 32'(cm_valid), 32'd1);
    chk("a_cm_be", 32'(cm_be), 32'hF);
    step();
    step();
    chk("a_free_back", 32'(free_count), 32'd8);
    chk("a_sb_empty", 32'(sb.size()), 32'd0);
    chk("a_cm_idle", 32'(cm_valid), 32'd0);

    // Forwarding: head=tail=2.
    dis_num = 2'd1;
    step();
    ex(0, 2, 32'h100, 32'hDEADBEEF, WORD);
    step();
    ldq(0, 32'h102, BYTE, 1'b1, 4'd3);
    ldq(1, 32'h103, BYTE, 1'b0, 4'd3);
    #1;
    chk_ld("lbu102", 0, FWD, !FWD, FWD ? 32'h000000AD : 32'h0);
    chk_ld("lb103", 1, FWD, !FWD, FWD ? 32'hFFFFFFDE : 32'h0);
    ld_valid = '0;
    ldq(0, 32'h100, WORD, 1'b0, 4'd2);
    #1;
    chk_ld("lw_older", 0, 1'b0, 1'b0, 32'h0);
    ld_valid = '0;
    dis_num = 2'd1;
    step();
    ex(0, 3, 32'h101, 32'h00000077, BYTE);
    step();
    ldq(0, 32'h100, WORD, 1'b0, 4'd4);
    ldq(1, 32'h101, BYTE, 1'b1, 4'd4);
    #1;
    chk_ld("lw_partial", 0, 1'b0, 1'b1, 32'h0);
    chk_ld("lbu101", 1, FWD, !FWD, FWD ? 32'h77 : 32'h0);
    ld_valid = '0;
    ldq(0, 32'h102, HALF, 1'b1, 4'd4);
    #1;
    chk_ld("lhu102", 0, FWD, !FWD, FWD ? 32'hDEAD : 32'h0);
    ld_valid = '0;
    dis_num = 2'd1;
    step();
    ldq(0, 32'h300, WORD, 1'b0, 4'd5);
    ldq(1, 32'h300, WORD, 1'b0, 4'd4);
    #1;
    chk_ld("ld_alloc", 0, 1'b0, 1'b1, 32'h0);
    chk_ld("ld_noovl", 1, 1'b0, 1'b0, 32'h0);
    ld_valid = '0;
    ex(0, 4, 32'h300, 32'h12345678, WORD);
    step();
    exp_cm(32'h100, 32'hDEADBEEF, 4'hF);
    exp_cm(32'h100, 32'h00007700, 4'h2);
    ret_num = 2'd2;
    step();
    exp_cm(32'h300, 32'h12345678, 4'hF);
    ret_num = 2'd1;
    step();
    repeat (4) step();
    chk("b_free", 32'(free_count), 32'd8);
    chk("b_sb_empty", 32'(sb.size()), 32'd0);

    // Move head to 6, then fill all 8 slots across the wrap.
    dis_num = 2'd1;
    step();
    ex(0, 5, 32'h500, 32'h5A5A5A5A, WORD);
    step();
    exp_cm(32'h500, 32'h5A5A5A5A, 4'hF);
    ret_num = 2'd1;
    step();
    repeat (2) step();
    cm_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      dis_num = 2'd2;
      step();
    end
    chk("c_full", 32'(free_count), 32'd0);
    chk("c_tail", 32'(dis_tail), 32'd14);
    for (int c = 0; c < 4; c++) begin
      for (int w = 0; w < 2; w++)
        ex(w, (6 + 2*c + w) % 8, 32'h1000 + 4*(2*c + w),
           32'hC0DE0000 + 32'(2*c + w), WORD);
      step();
    end
    for (int c = 0; c < 4; c++) begin
      exp_cm(32'h1000 + 32'(8*c), 32'hC0DE0000 + 32'(2*c), 4'hF);
      exp_cm(32'h1004 + 32'(8*c), 32'hC0DE0001 + 32'(2*c), 4'hF);
      ret_num = 2'd2;
      step();
      chk("c_hold_addr", cm_addr, 32'h1000);
      chk("c_hold_data", cm_data, 32'hC0DE0000);
    end
    step();
    chk("c_hold_be", 32'(cm_be), 32'hF);
    chk("c_hold_valid", 32'(cm_valid), 32'd1);
    cm_ready = 1'b1;
    step();
    cm_ready = 1'b0;
    chk("c_free_one", 32'(free_count), 32'd1);
    chk("c_dis_idx6", 32'(dis_idx[2:0]), 32'd6);
    dis_num = 2'd1;
    step();
    chk("c_refull", 32'(free_count), 32'd0);
    ex(0, 6, 32'h2000, 32'h55, WORD);
    step();
    exp_cm(32'h2000, 32'h55, 4'hF);
    ret_num = 2'd1;
    cm_ready = 1'b1;
    step();
    repeat (9) step();
    chk("c_free", 32'(free_count), 32'd8);
    chk("c_sb_empty", 32'(sb.size()), 32'd0);

    // Rollback: head=rptr=tail=15 (slot 7).
    cm_ready = 1'b0;
    dis_num = 2'd2;
    step();
    dis_num = 2'd1;
    step();
    ex(0, 7, 32'h3000, 32'hD0, WORD);
    ex(1, 0, 32'h3004, 32'hD1, WORD);
    step();
    ex(0, 1, 32'h3008, 32'hD2, WORD);
    step();
    exp_cm(32'h3000, 32'hD0, 4'hF);
    exp_cm(32'h3004, 32'hD1, 4'hF);
    ret_num = 2'd2;
    step();
    exp_cm(32'h3008, 32'hD2, 4'hF);
    ret_num = 2'd1;
    step();
    dis_num = 2'd2;
    step();
    dis_num = 2'd1;
    step();
    chk("d_free_pre", 32'(free_count), 32'd2);
    rb_valid = 1'b1;
    rb_tail  = 4'd2;
    dis_num  = 2'd2;
    ex(0, 2, 32'h4000, 32'hBAD, WORD);
    cm_ready = 1'b1;
    step();
    chk("d_tail", 32'(dis_tail), 32'd2);
    chk("d_free_rb", 32'(free_count), 32'd6);
    ldq(0, 32'h4000, WORD, 1'b0, 4'd5);
    ldq(1, 32'h3008, WORD, 1'b0, 4'd5);
    #1;
    chk_ld("d_killed", 0, 1'b0, 1'b0, 32'h0);
    chk_ld("d_ret_fwd", 1, FWD, !FWD, FWD ? 32'hD2 : 32'h0);
    ld_valid = '0;
    repeat (4) step();
    chk("d_free", 32'(free_count), 32'd8);
    chk("d_sb_empty", 32'(sb.size()), 32'd0);
    chk("d_cm_idle", 32'(cm_valid), 32'd0);

    repeat (2) step();
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
